// File: rtl/priority_sched_pkg.sv
// rtl/priority_sched_pkg.sv - shared sizes and FSM state type for the priority request scheduler
package priority_sched_pkg;

   localparam int N     = 8;
   localparam int IDX_W = 3;
   localparam int CNT_W = 4;

   typedef enum logic {
      ST_IDLE,
      ST_OFFER
   } state_t;

endpackage

// File: rtl/pending_scan.sv
// rtl/pending_scan.sv - combinational highest-set-index, empty flag and popcount of a request vector
module pending_scan
   import priority_sched_pkg::*;
(
   input  logic [N-1:0]     vec,
   output logic [IDX_W-1:0] idx,
   output logic             none,
   output logic [CNT_W-1:0] cnt
);

   // Ascending walk: the last set bit seen is the highest, so the MSB wins.
   always_comb begin
      idx = '0;
      cnt = '0;
      for (int i = 0; i < N; i++) begin
         if (vec[i]) begin
            idx = IDX_W'(i);
            cnt = cnt + CNT_W'(1);
         end
      end
      none = (vec == '0);
   end

endmodule

// File: rtl/priority_request_scheduler.sv
// rtl/priority_request_scheduler.sv - sticky pending vector with MSB-first valid/ready grant offer
module priority_request_scheduler #(
   parameter int N     = 8,
   parameter int IDX_W = 3,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     req_in,
   output logic             gnt_valid,
   input  logic             gnt_ready,
   output logic [IDX_W-1:0] gnt_idx,
   output logic [CNT_W-1:0] pend_cnt,
   output logic             idle,
   output logic             overrun
);

   import priority_sched_pkg::*;

   state_t             state;
   state_t             state_nx;
   logic [N-1:0]       pend;
   logic [N-1:0]       pend_nx;
   logic [N-1:0]       clr;
   logic [IDX_W-1:0]   idx_nx;
   logic               accept;

   logic [IDX_W-1:0]   cur_idx;
   logic               cur_none;
   logic [CNT_W-1:0]   cur_cnt;
   logic [IDX_W-1:0]   nx_idx;
   logic               nx_none;
   logic [CNT_W-1:0]   nx_cnt;

   pending_scan u_scan_cur (
      .vec  (pend),
      .idx  (cur_idx),
      .none (cur_none),
      .cnt  (cur_cnt)
   );

   pending_scan u_scan_nx (
      .vec  (pend_nx),
      .idx  (nx_idx),
      .none (nx_none),
      .cnt  (nx_cnt)
   );

   assign gnt_valid = (state == ST_OFFER);
   assign accept    = gnt_valid && gnt_ready;
   assign idle      = cur_none && !gnt_valid;

   // New requests are OR'd in after the clear, so a re-request on the accepted bit survives.
   always_comb begin
      clr = '0;
      if (accept) begin
         clr[gnt_idx] = 1'b1;
      end
      pend_nx = (pend & ~clr) | req_in;
   end

   always_comb begin
      state_nx = state;
      idx_nx   = gnt_idx;
      case (state)
         ST_IDLE: begin
            if (!cur_none) begin
               idx_nx   = cur_idx;
               state_nx = ST_OFFER;
            end
         end
         ST_OFFER: begin
            if (accept) begin
               if (nx_none) begin
                  state_nx = ST_IDLE;
               end else begin
                  idx_nx = nx_idx;
               end
            end
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         pend     <= '0;
         gnt_idx  <= '0;
         pend_cnt <= '0;
         overrun  <= 1'b0;
      end else begin
         state    <= state_nx;
         pend     <= pend_nx;
         gnt_idx  <= idx_nx;
         pend_cnt <= nx_cnt;
         if (|(req_in & pend & ~clr)) begin
            overrun <= 1'b1;
         end
      end
   end

   // The registered count must always track the stored vector.
   a_cnt_tracks_pend : assert property (@(posedge clk) disable iff (rst) pend_cnt == cur_cnt);

endmodule

// File: tb/tb_priority_request_scheduler.sv
// tb/tb_priority_request_scheduler.sv - directed vector table plus randomized run against a set-based model
module tb_priority_request_scheduler;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] req_in;
   logic       gnt_valid;
   logic       gnt_ready;
   logic [2:0] gnt_idx;
   logic [3:0] pend_cnt;
   logic       idle;
   logic       overrun;

   always #5 clk = ~clk;

   priority_request_scheduler dut (
      .clk       (clk),
      .rst       (rst),
      .req_in    (req_in),
      .gnt_valid (gnt_valid),
      .gnt_ready (gnt_ready),
      .gnt_idx   (gnt_idx),
      .pend_cnt  (pend_cnt),
      .idle      (idle),
      .overrun   (overrun)
   );

   typedef struct {
      logic       rst;
      logic [7:0] req;
      logic       rdy;
      logic       v;
      int         idx;
      int         cnt;
      logic       idl;
      logic       ovr;
   } vec_t;

   vec_t tbl[$];
   int   pass_cnt  = 0;
   int   total_cnt = 0;

   // Reference model: the set of outstanding request numbers and the grant currently on offer.
   bit   m_pend[8];
   bit   m_off;
   int   m_idx;
   bit   m_ovr;

   function automatic int m_count();
      int c = 0;
      for (int i = 0; i < 8; i++) c += m_pend[i] ? 1 : 0;
      return c;
   endfunction

   function automatic int m_highest();
      for (int i = 7; i >= 0; i--) if (m_pend[i]) return i;
      return -1;
   endfunction

   task automatic model_edge(input logic r, input logic [7:0] q, input logic rd);
      bit accepted;
      int taken;
      int h;
      if (r) begin
         for (int i = 0; i < 8; i++) m_pend[i] = 0;
         m_off = 0;
         m_idx = 0;
         m_ovr = 0;
      end else begin
         accepted = m_off && rd;
         taken    = accepted ? m_idx : -1;
         h        = m_highest();
         for (int i = 0; i < 8; i++)
            if (q[i] && m_pend[i] && i != taken) m_ovr = 1;
         if (!m_off) begin
            if (h >= 0) begin
               m_off = 1;
               m_idx = h;
            end
         end
         if (taken >= 0) m_pend[taken] = 0;
         for (int i = 0; i < 8; i++) if (q[i]) m_pend[i] = 1;
         if (accepted) begin
            h = m_highest();
            if (h >= 0) m_idx = h;
            else m_off = 0;
         end
      end
   endtask

   task automatic check(input string name, input int act, input int exp);
      total_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   task automatic step(input logic r, input logic [7:0] q, input logic rd);
      rst       = r;
      req_in    = q;
      gnt_ready = rd;
      @(posedge clk);
      model_edge(r, q, rd);
      #1;
   endtask

   task automatic add(input logic r, input logic [7:0] q, input logic rd, input logic v,
                      input int idx, input int cnt, input logic idl, input logic ovr);
      vec_t e;
      e.rst = r; e.req = q; e.rdy = rd; e.v = v; e.idx = idx; e.cnt = cnt; e.idl = idl; e.ovr = ovr;
      tbl.push_back(e);
   endtask

   initial begin
      logic       r;
      logic [7:0] q;
      logic       rd;

      // reset with all requests asserted
      add(1, 8'hFF, 0, 0, 0, 0, 1, 0);
      add(1, 8'hFF, 0, 0, 0, 0, 1, 0);
      add(0, 8'h00, 0, 0, 0, 0, 1, 0);
      // single event, two-edge latency, then accept
      add(0, 8'h10, 0, 0, 0, 1, 0, 0);
      add(0, 8'h00, 0, 1, 4, 1, 0, 0);
      add(0, 8'h00, 1, 0, 0, 0, 1, 0);
      // offer stays frozen while a higher request arrives
      add(0, 8'h04, 0, 0, 0, 1, 0, 0);
      add(0, 8'h00, 0, 1, 2, 1, 0, 0);
      add(0, 8'h80, 0, 1, 2, 2, 0, 0);
      add(0, 8'h00, 0, 1, 2, 2, 0, 0);
      add(0, 8'h00, 1, 1, 7, 1, 0, 0);
      add(0, 8'h00, 1, 0, 0, 0, 1, 0);
      // back-to-back drain of all eight
      add(0, 8'hFF, 1, 0, 0, 8, 0, 0);
      for (int i = 7; i >= 0; i--) add(0, 8'h00, 1, 1, i, i + 1, 0, 0);
      add(0, 8'h00, 1, 0, 0, 0, 1, 0);
      // re-request on the accepted bit
      add(0, 8'h08, 0, 0, 0, 1, 0, 0);
      add(0, 8'h00, 0, 1, 3, 1, 0, 0);
      add(0, 8'h08, 1, 1, 3, 1, 0, 0);
      add(0, 8'h00, 1, 0, 0, 0, 1, 0);
      // re-request while still pending
      add(0, 8'h20, 0, 0, 0, 1, 0, 0);
      add(0, 8'h00, 0, 1, 5, 1, 0, 0);
      add(0, 8'h20, 0, 1, 5, 1, 0, 1);
      add(0, 8'h00, 1, 0, 0, 0, 1, 1);
      // reset in the middle of an offer
      add(0, 8'h07, 0, 0, 0, 3, 0, 1);
      add(0, 8'h00, 0, 1, 2, 3, 0, 1);
      add(1, 8'h00, 0, 0, 0, 0, 1, 0);
      add(0, 8'h00, 1, 0, 0, 0, 1, 0);
      add(0, 8'h00, 1, 0, 0, 0, 1, 0);

      for (int k = 0; k < tbl.size(); k++) begin
         step(tbl[k].rst, tbl[k].req, tbl[k].rdy);
         check($sformatf("vec%0d.gnt_valid", k), int'(gnt_valid), int'(tbl[k].v));
         if (tbl[k].v || tbl[k].rst) check($sformatf("vec%0d.gnt_idx", k), int'(gnt_idx), tbl[k].idx);
         check($sformatf("vec%0d.pend_cnt", k), int'(pend_cnt), tbl[k].cnt);
         check($sformatf("vec%0d.idle", k), int'(idle), int'(tbl[k].idl));
         check($sformatf("vec%0d.overrun", k), int'(overrun), int'(tbl[k].ovr));
      end

      for (int k = 0; k < 600; k++) begin
         r  = ($urandom_range(0, 99) == 0);
         q  = ($urandom_range(0, 2) == 0) ? 8'($urandom & $urandom) : 8'h00;
         rd = 1'($urandom_range(0, 1));
         step(r, q, rd);
         check($sformatf("rnd%0d.gnt_valid", k), int'(gnt_valid), int'(m_off));
         if (m_off) check($sformatf("rnd%0d.gnt_idx", k), int'(gnt_idx), m_idx);
         check($sformatf("rnd%0d.pend_cnt", k), int'(pend_cnt), m_count());
         check($sformatf("rnd%0d.idle", k), int'(idle), int'(m_count() == 0 && !m_off));
         check($sformatf("rnd%0d.overrun", k), int'(overrun), int'(m_ovr));
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
